// File: rtl/vga_scan_timer_if.sv
// VGA scan-timer signal bundle: colour-mapper inputs, pixel coordinates,
// strobes and the DAC-facing outputs. The timer is the master; the
// colour mapper / game logic / DAC side is the slave.
//
// Handshake semantics: there is no valid/ready pair here. pix_en is a
// one-Clk strobe meaning "the pixel advances at the end of this cycle";
// Red_in/Green_in/Blue_in are only sampled on pix_en cycles, and
// frame_done is a one-Clk strobe at the start of vertical blank.
interface vga_scan_timer_if;
    logic [7:0] Red_in;
    logic [7:0] Green_in;
    logic [7:0] Blue_in;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       pix_en;
    logic       frame_done;
    logic       VGA_CLK;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;

    modport master (
        input  Red_in, Green_in, Blue_in,
        output DrawX, DrawY, pix_en, frame_done,
        output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        output VGA_R, VGA_G, VGA_B
    );

    modport slave (
        output Red_in, Green_in, Blue_in,
        input  DrawX, DrawY, pix_en, frame_done,
        input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        input  VGA_R, VGA_G, VGA_B
    );
endinterface

// File: rtl/vga_scan_timer.sv
// Raster-scan timing generator for the DE2 VGA DAC. Divides Clk down to
// the pixel rate, runs the horizontal/vertical counters, decodes sync and
// blank, and registers colour + sync + blank together so everything reaches
// the DAC one pixel period behind DrawX/DrawY, equally delayed.
module vga_scan_timer #(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input logic             Clk,
    input logic             Reset,
    vga_scan_timer_if.master vga
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] X_LAST     = 10'(H_TOT - 1);
    localparam logic [9:0] Y_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0] X_VIS      = 10'(H_VIS);
    localparam logic [9:0] Y_VIS      = 10'(V_VIS);
    localparam logic [9:0] Y_VIS_LAST = 10'(V_VIS - 1);
    localparam logic [9:0] HS_START   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             vga_clk_q, vga_clk_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             blank_n_q, blank_n_d;
    logic [7:0]       r_q, r_d;
    logic [7:0]       g_q, g_d;
    logic [7:0]       b_q, b_d;

    logic             pix_en;
    logic             vga_clk_next;
    logic             visible;
    logic             hs_active;
    logic             vs_active;
    logic             frame_done;

    // With a divide-by-one the pixel clock is simply held high; otherwise it
    // is high for the upper half of the divider count.
    if (CLK_DIV == 1) begin : g_div_one
        assign vga_clk_next = 1'b1;
    end else begin : g_div_many
        assign vga_clk_next = (div_d >= DIV_W'(CLK_DIV / 2));
    end

    // Divider: wraps 0..CLK_DIV-1, pixel strobe on the last count.
    // Reset gates the strobe so nothing advances while Reset is held.
    always_comb begin
        div_d     = div_q;
        pix_en    = 1'b0;
        vga_clk_d = vga_clk_next;
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
        pix_en = !Reset && (div_q == DIV_LAST);
    end

    // Counters: DrawX steps every pixel, DrawY steps when DrawX wraps.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_en) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // Decode visibility, sync windows and the start-of-vblank strobe from
    // the current (pre-register) counters.
    always_comb begin
        visible    = (x_q < X_VIS) && (y_q < Y_VIS);
        hs_active  = (x_q >= HS_START) && (x_q < HS_END);
        vs_active  = (y_q >= VS_START) && (y_q < VS_END);
        frame_done = pix_en && (x_q == X_LAST) && (y_q == Y_VIS_LAST);
    end

    // Output stage: capture sync, blank and gated colour on each pixel strobe.
    always_comb begin
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        if (pix_en) begin
            hs_d      = !hs_active;
            vs_d      = !vs_active;
            blank_n_d = visible;
            r_d       = visible ? vga.Red_in   : 8'h00;
            g_d       = visible ? vga.Green_in : 8'h00;
            b_d       = visible ? vga.Blue_in  : 8'h00;
        end
    end

    // State registers with synchronous reset to the idle/blank state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            vga_clk_q <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            r_q       <= 8'h00;
            g_q       <= 8'h00;
            b_q       <= 8'h00;
        end else begin
            div_q     <= div_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vga_clk_q <= vga_clk_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

    assign vga.DrawX       = x_q;
    assign vga.DrawY       = y_q;
    assign vga.pix_en      = pix_en;
    assign vga.frame_done  = frame_done;
    assign vga.VGA_CLK     = vga_clk_q;
    assign vga.VGA_HS      = hs_q;
    assign vga.VGA_VS      = vs_q;
    assign vga.VGA_BLANK_N = blank_n_q;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.VGA_R       = r_q;
    assign vga.VGA_G       = g_q;
    assign vga.VGA_B       = b_q;

endmodule

// File: tb/tb_vga_scan_timer.sv
// Bench for vga_scan_timer. Two instances on a shrunken raster (23x15)
// share Clk/Reset/colour: one divides by 2, one by 1. The reference model
// derives every expected output in closed form from the number of clock
// edges since the last reset.
module tb_vga_scan_timer;

    localparam int HV = 16, HF = 2, HS = 3, HB = 2;
    localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    // clock / reset
    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic [7:0] red_in, green_in, blue_in;
    bit         const_ff;

    int n_checks;
    int n_pass;
    int n_cyc;   // edges since the last reset edge

    int         div_of [2];
    logic       exp_hs [2];
    logic       exp_vs [2];
    logic       exp_bn [2];
    logic [7:0] exp_r  [2];
    logic [7:0] exp_g  [2];
    logic [7:0] exp_b  [2];

    vga_scan_timer_if if_d2();
    vga_scan_timer_if if_d1();

    assign if_d2.Red_in   = red_in;
    assign if_d2.Green_in = green_in;
    assign if_d2.Blue_in  = blue_in;
    assign if_d1.Red_in   = red_in;
    assign if_d1.Green_in = green_in;
    assign if_d1.Blue_in  = blue_in;

    vga_scan_timer #(
        .CLK_DIV(2), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut_d2 (
        .Clk(Clk), .Reset(Reset), .vga(if_d2)
    );

    vga_scan_timer #(
        .CLK_DIV(1), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut_d1 (
        .Clk(Clk), .Reset(Reset), .vga(if_d1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, n_cyc);
        end
    endtask

    // Closed-form expectations for one instance in the current cycle.
    task automatic check_inst(
        input int i, input bit rst,
        input logic [9:0] dx, input logic [9:0] dy,
        input logic pe, input logic fd, input logic vc,
        input logic hs, input logic vs, input logic bn, input logic sn,
        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b
    );
        int    d, p, x, y;
        logic  pe_e, fd_e, vc_e;
        string pfx;
        d    = div_of[i];
        p    = n_cyc / d;
        x    = p % HT;
        y    = (p / HT) % VT;
        pe_e = !rst && ((n_cyc % d) == d - 1);
        fd_e = pe_e && ((p % (HT * VT)) == (VV - 1) * HT + HT - 1);
        vc_e = (n_cyc > 0) && ((n_cyc % d) >= d / 2);
        pfx  = $sformatf("div%0d", d);
        check({pfx, ".DrawX"},       32'(dx), 32'(x));
        check({pfx, ".DrawY"},       32'(dy), 32'(y));
        check({pfx, ".pix_en"},      32'(pe), 32'(pe_e));
        check({pfx, ".frame_done"},  32'(fd), 32'(fd_e));
        check({pfx, ".VGA_CLK"},     32'(vc), 32'(vc_e));
        check({pfx, ".VGA_HS"},      32'(hs), 32'(exp_hs[i]));
        check({pfx, ".VGA_VS"},      32'(vs), 32'(exp_vs[i]));
        check({pfx, ".VGA_BLANK_N"}, 32'(bn), 32'(exp_bn[i]));
        check({pfx, ".VGA_SYNC_N"},  32'(sn), 32'(0));
        check({pfx, ".VGA_R"},       32'(r),  32'(exp_r[i]));
        check({pfx, ".VGA_G"},       32'(g),  32'(exp_g[i]));
        check({pfx, ".VGA_B"},       32'(b),  32'(exp_b[i]));
    endtask

    // Advance the model across one rising edge.
    task automatic model_edge(input bit rst);
        int   d, p, x, y;
        logic vis;
        if (rst) begin
            n_cyc = 0;
            for (int i = 0; i < 2; i++) begin
                exp_hs[i] = 1'b1;
                exp_vs[i] = 1'b1;
                exp_bn[i] = 1'b0;
                exp_r[i]  = 8'h00;
                exp_g[i]  = 8'h00;
                exp_b[i]  = 8'h00;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                d = div_of[i];
                if ((n_cyc % d) == d - 1) begin
                    p   = n_cyc / d;
                    x   = p % HT;
                    y   = (p / HT) % VT;
                    vis = (x < HV) && (y < VV);
                    exp_hs[i] = !((x >= HV + HF) && (x < HV + HF + HS));
                    exp_vs[i] = !((y >= VV + VF) && (y < VV + VF + VS));
                    exp_bn[i] = vis;
                    exp_r[i]  = vis ? red_in   : 8'h00;
                    exp_g[i]  = vis ? green_in : 8'h00;
                    exp_b[i]  = vis ? blue_in  : 8'h00;
                end
            end
            n_cyc++;
        end
    endtask

    // driver: one Clk cycle, starting and ending just after a falling edge
    task automatic step(input bit rst);
        Reset = rst;
        if (const_ff) begin
            red_in   = 8'hFF;
            green_in = 8'hFF;
            blue_in  = 8'hFF;
        end else begin
            red_in   = 8'($urandom_range(0, 255));
            green_in = 8'($urandom_range(0, 255));
            blue_in  = 8'($urandom_range(0, 255));
        end
        #1;
        check_inst(0, rst, if_d2.DrawX, if_d2.DrawY, if_d2.pix_en, if_d2.frame_done,
                   if_d2.VGA_CLK, if_d2.VGA_HS, if_d2.VGA_VS, if_d2.VGA_BLANK_N,
                   if_d2.VGA_SYNC_N, if_d2.VGA_R, if_d2.VGA_G, if_d2.VGA_B);
        check_inst(1, rst, if_d1.DrawX, if_d1.DrawY, if_d1.pix_en, if_d1.frame_done,
                   if_d1.VGA_CLK, if_d1.VGA_HS, if_d1.VGA_VS, if_d1.VGA_BLANK_N,
                   if_d1.VGA_SYNC_N, if_d1.VGA_R, if_d1.VGA_G, if_d1.VGA_B);
        model_edge(rst);
        @(negedge Clk);
    endtask

    initial begin
        int target;
        n_checks  = 0;
        n_pass    = 0;
        n_cyc     = 0;
        const_ff  = 1'b0;
        div_of[0] = 2;
        div_of[1] = 1;
        red_in    = 8'h00;
        green_in  = 8'h00;
        blue_in   = 8'h00;
        Reset     = 1'b1;

        @(posedge Clk);
        @(negedge Clk);
        model_edge(1'b1);

        // reset hold
        repeat (5) step(1'b1);

        // two full frames of the divide-by-2 raster, random colour
        repeat (2 * HT * VT * 2 + 7) step(1'b0);

        // full-scale colour for a whole frame: output colour follows blank
        const_ff = 1'b1;
        repeat (HT * VT * 2) step(1'b0);
        const_ff = 1'b0;

        // reset mid-line at x=11, y=4 with the divider on its odd phase
        step(1'b1);
        target = (4 * HT + 11) * 2 + 1;
        while (n_cyc < target) step(1'b0);
        step(1'b1);
        repeat (HT * 2 * 3) step(1'b0);

        // random mid-frame resets
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(20, 700)) step(1'b0);
            repeat ($urandom_range(1, 3)) step(1'b1);
        end
        repeat (HT * VT * 2) step(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_scan_timer.md
# vga_scan_timer

Raster-scan timing generator driving the DE2 VGA DAC and supplying the pixel coordinates `DrawX`/`DrawY` that the colour mapper consumes. It divides the 50 MHz system clock down to the pixel rate and runs horizontal and vertical counters over an 800×525 (640×480 visible) frame. It registers the mapper's combinational RGB result together with sync and blank, so colour and sync reach the DAC aligned. It also gives game logic a one-cycle `frame_done` strobe at the start of vertical blank for sprite and maze updates.

## Interface
- `CLK_DIV`, 2: system clocks per pixel; ≥1.
- `H_VIS`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front-porch pixels.
- `H_SYNC`, 96: HS pulse pixels.
- `H_BP`, 48: horizontal back-porch pixels.
- `V_VIS`, 480: visible lines.
- `V_FP`, 10: vertical front-porch lines.
- `V_SYNC`, 2: VS pulse lines.
- `V_BP`, 33: vertical back-porch lines.
- `Clk` in 1: system clock, 50 MHz. One clock domain only.
- `Reset` in 1: synchronous, active-high.
- `Red_in`, `Green_in`, `Blue_in` in 8 each: colour-mapper output for the current `DrawX`/`DrawY`.
- `DrawX` out 10: horizontal counter, 0..H_TOT-1.
- `DrawY` out 10: vertical counter, 0..V_TOT-1.
- `pix_en` out 1: one-`Clk` strobe; the pixel advances on this cycle.
- `frame_done` out 1: one-`Clk` strobe at the start of vertical blank.
- `VGA_CLK` out 1: pixel clock to the DAC.
- `VGA_HS` out 1: horizontal sync, active low.
- `VGA_VS` out 1: vertical sync, active low.
- `VGA_BLANK_N` out 1: 0 during blank.
- `VGA_SYNC_N` out 1: tied to 0.
- `VGA_R`, `VGA_G`, `VGA_B` out 8 each: registered colour.

## Operation
- Derived totals: H_TOT = H_VIS+H_FP+H_SYNC+H_BP (default 800); V_TOT = V_VIS+V_FP+V_SYNC+V_BP (default 525).
- **Divider:** `div` counts 0..CLK_DIV-1 and wraps.
  - `pix_en` = 1 when div == CLK_DIV-1.
  - `VGA_CLK` is registered, 1 while div ≥ CLK_DIV/2 (integer division).
  - With CLK_DIV = 1: `pix_en` is held at 1 and `VGA_CLK` is driven as ~`Clk`-phase-independent 1.
- **Counters:** `DrawX`/`DrawY` are registers and change only on `pix_en`.
  - `DrawX` increments; at H_TOT-1 it wraps to 0.
  - When `DrawX` wraps, `DrawY` increments; at V_TOT-1 it wraps to 0.
- **Visibility:** a pixel is visible when `DrawX` < H_VIS and `DrawY` < V_VIS.
- **Sync decode:**
  - HS low when H_VIS+H_FP ≤ `DrawX` < H_VIS+H_FP+H_SYNC (656..751).
  - VS low when V_VIS+V_FP ≤ `DrawY` < V_VIS+V_FP+V_SYNC (490..491).
- **Output stage:** on each `pix_en`, register `VGA_HS`, `VGA_VS`, `VGA_BLANK_N` and RGB from the current counters and `*_in` inputs.
  - RGB is forced to 0 when the pixel is not visible.
  - Output is therefore exactly one pixel period behind `DrawX`/`DrawY`, and every output is delayed equally.
- **`frame_done`:** 1 for exactly one `Clk`, on the `pix_en` cycle where the counters step from (H_TOT-1, V_VIS-1) to (0, V_VIS).

## Timing
- **Reset values:** `div`=0, `DrawX`=0, `DrawY`=0, `pix_en`=0, `frame_done`=0, `VGA_CLK`=0, `VGA_HS`=1, `VGA_VS`=1, `VGA_BLANK_N`=0, RGB=0. `VGA_SYNC_N`=0 always.
- **After Reset deasserts:** first `pix_en` occurs in the CLK_DIV-th `Clk` cycle. `DrawX` reads 1 on the following cycle.
- **Reset mid-frame:** on the next edge all state returns to reset values, regardless of `div` phase or position in the frame. No partial sync pulse is extended.
- **Periods:** line = H_TOT·CLK_DIV `Clk` cycles (1600); frame = H_TOT·V_TOT·CLK_DIV (840 000); `frame_done` period = 840 000.
- **Input sampling:** `*_in` are sampled only on `pix_en` cycles. Upstream logic may be combinational from `DrawX`/`DrawY` and settle within CLK_DIV-1 cycles.
- **Simultaneous wraps:** `DrawX` and `DrawY` wrap on the same edge at (799, 524) → (0, 0). `frame_done` is not asserted there.

## Test plan
- **Reset hold:** Reset high 5 cycles → all outputs at reset values. Deassert → `pix_en` pulses every 2nd cycle; `DrawX`=1 after cycle 2; `VGA_CLK` square wave at 25 MHz.
- **Horizontal sync:** run one line → `VGA_HS` low for 96 pixels (192 `Clk`), falling one pixel after `DrawX`=656. `DrawY` increments when `DrawX` wraps 799→0.
- **Frame timing:** run 2 frames → `VGA_VS` low for 2 lines starting after `DrawY`=490. `frame_done` pulses once per 840 000 cycles, each pulse 1 `Clk` wide, coincident with `DrawY` 479→480.
- **Blank gating:** drive `*_in` = 8'hFF constant → `VGA_R`/`VGA_G`/`VGA_B` = FF exactly when registered `VGA_BLANK_N`=1, otherwise 00. Include the edges at x=640 and y=480.
- **Reset mid-line:** assert Reset at `DrawX`=300, `DrawY`=200, odd `div` phase → next cycle `DrawX`=`DrawY`=0 and `VGA_HS`=`VGA_VS`=1. Restart timing is identical to the first reset.
- **CLK_DIV=1 build:** one line = 800 cycles; `pix_en` constantly 1; `DrawX` increments every cycle and wraps 799→0.
